// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC/fetch stage with jump predecode, branch redirect and stall skid register
// Optional interrupt entry is compiled in with `define FETCH_IRQ_EN.
module fetch_unit #(
   parameter logic [15:0] RESET_PC   = 16'h0001
`ifdef FETCH_IRQ_EN
   ,
   parameter logic [15:0] IRQ_VECTOR = 16'h0000
`endif
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] pc,
   input  logic [15:0] instr_in,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   output logic [15:0] instr_out,
   output logic [15:0] instr_pc,
   output logic        instr_valid
`ifdef FETCH_IRQ_EN
   ,
   input  logic        irq,
   input  logic        irq_done,
   output logic [15:0] epc
`endif
);

   logic [15:0] pc_q, pc_d;
   logic [15:0] pc_d1_q, pc_d1_d;
   logic        fetch_v_q, fetch_v_d;
   logic [15:0] hold_reg_q, hold_reg_d;
   logic        hold_v_q, hold_v_d;
   logic        valid_raw;
   logic        jump_hit;
   logic [15:0] jump_target;
   logic        irq_entry;

`ifdef FETCH_IRQ_EN
   logic        in_irq_q, in_irq_d;
   logic [15:0] epc_q, epc_d;
`endif

   always_comb begin
      valid_raw   = fetch_v_q | hold_v_q;
      // Memory data is zeroed when nothing is in flight so idle/reset outputs read as 0.
      instr_out   = hold_v_q ? hold_reg_q : (fetch_v_q ? instr_in : 16'h0000);
      instr_pc    = pc_d1_q;
`ifdef FETCH_IRQ_EN
      irq_entry   = irq & ~in_irq_q & valid_raw & ~stall & ~branch_taken;
`else
      irq_entry   = 1'b0;
`endif
      instr_valid = valid_raw & ~irq_entry;
      jump_hit    = valid_raw & (instr_out[15:12] == 4'hF);
      jump_target = {pc_d1_q[15:12], instr_out[11:0]};
      pc          = pc_q;
   end

   always_comb begin
      pc_d       = pc_q;
      pc_d1_d    = pc_d1_q;
      fetch_v_d  = fetch_v_q;
      hold_reg_d = hold_reg_q;
      hold_v_d   = hold_v_q;
`ifdef FETCH_IRQ_EN
      in_irq_d   = in_irq_q;
      epc_d      = epc_q;
      if (irq_done) in_irq_d = 1'b0;
`endif
      if (branch_taken) begin
         pc_d      = branch_target;
         fetch_v_d = 1'b0;
         hold_v_d  = 1'b0;
      end else if (irq_entry) begin
`ifdef FETCH_IRQ_EN
         epc_d     = pc_d1_q;
         pc_d      = IRQ_VECTOR;
         in_irq_d  = 1'b1;
`endif
         fetch_v_d = 1'b0;
         hold_v_d  = 1'b0;
      end else if (stall && valid_raw) begin
         // pc keeps being re-read, so the successor is still at instr_in on release.
         if (!hold_v_q) begin
            hold_reg_d = instr_in;
            hold_v_d   = 1'b1;
         end
         fetch_v_d = 1'b0;
      end else if (jump_hit) begin
         pc_d      = jump_target;
         pc_d1_d   = pc_q;
         fetch_v_d = 1'b0;
         hold_v_d  = 1'b0;
      end else begin
         pc_d      = pc_q + 16'h0001;
         pc_d1_d   = pc_q;
         fetch_v_d = 1'b1;
         hold_v_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         pc_d1_q    <= 16'h0000;
         fetch_v_q  <= 1'b0;
         hold_reg_q <= 16'h0000;
         hold_v_q   <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         pc_d1_q    <= pc_d1_d;
         fetch_v_q  <= fetch_v_d;
         hold_reg_q <= hold_reg_d;
         hold_v_q   <= hold_v_d;
      end
   end

`ifdef FETCH_IRQ_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_irq_q <= 1'b0;
         epc_q    <= 16'h0000;
      end else begin
         in_irq_q <= in_irq_d;
         epc_q    <= epc_d;
      end
   end

   assign epc = epc_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: address-level model plus directed literals
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pc;
   logic [15:0] instr_in;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic [15:0] instr_out;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        irq;
   logic        irq_done;
`ifdef FETCH_IRQ_EN
   logic [15:0] epc;
`endif

   int total = 0;
   int bad   = 0;

   fetch_unit dut (
      .clk(clk), .rst(rst), .pc(pc), .instr_in(instr_in),
      .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
      .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid)
`ifdef FETCH_IRQ_EN
      , .irq(irq), .irq_done(irq_done), .epc(epc)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] prog(input logic [15:0] a);
      case (a)
         16'd1:   return 16'h3011;
         16'd2:   return 16'h3121;
         16'd5:   return 16'h3451;
         16'd6:   return 16'h3561;
         16'd33:  return 16'hF001;
         16'd34:  return 16'h8330;
         default: return {4'h2, a[11:0]};
      endcase
   endfunction

   function automatic bit is_jump(input logic [15:0] a);
      logic [15:0] w;
      w = prog(a);
      return w[15:12] == 4'hF;
   endfunction

   function automatic logic [15:0] jump_dest(input logic [15:0] a);
      logic [15:0] w;
      w = prog(a);
      return {a[15:12], w[11:0]};
   endfunction

   always @(posedge clk) instr_in <= prog(pc);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: which address is being fetched, and which address (if any) is on display.
   logic [15:0] m_pc, m_a, m_epc;
   logic        m_v, m_in_irq, m_entry;

   assign m_entry = irq & ~m_in_irq & m_v & ~stall & ~branch_taken;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc <= 16'h0001; m_v <= 1'b0; m_a <= 16'h0000;
         m_in_irq <= 1'b0; m_epc <= 16'h0000;
      end else begin
         if (irq_done) m_in_irq <= 1'b0;
         if (branch_taken) begin
            m_pc <= branch_target; m_v <= 1'b0;
         end else if (m_entry) begin
            m_epc <= m_a; m_pc <= 16'h0000; m_v <= 1'b0; m_in_irq <= 1'b1;
         end else if (stall && m_v) begin
            m_pc <= m_pc;
         end else if (m_v && is_jump(m_a)) begin
            m_pc <= jump_dest(m_a); m_v <= 1'b0;
         end else begin
            m_v <= 1'b1; m_a <= m_pc; m_pc <= m_pc + 16'h0001;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("m_pc", pc, m_pc);
         chk("m_valid", instr_valid, m_v & ~m_entry);
         if (m_v && !m_entry) begin
            chk("m_instr", instr_out, prog(m_a));
            chk("m_instr_pc", instr_pc, m_a);
         end
`ifdef FETCH_IRQ_EN
         chk("m_epc", epc, m_epc);
`endif
      end
   end

   task automatic wait_shown(input logic [15:0] a, input int limit);
      bit found = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (instr_valid && instr_pc == a) begin
            found = 1;
            break;
         end
      end
      chk("wait_shown", {15'd0, found}, 32'd1);
   endtask

   task automatic chk_show(input string name, input logic [15:0] ins, input logic [15:0] a);
      chk({name, "_valid"}, instr_valid, 1'b1);
      chk({name, "_instr"}, instr_out, ins);
      chk({name, "_pc"}, instr_pc, a);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
      irq = 1'b0; irq_done = 1'b0;
      #2;
      chk("rst_pc", pc, 16'h0001);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_instr", instr_out, 16'h0000);
      chk("rst_instr_pc", instr_pc, 16'h0000);
      @(negedge clk); #1 rst = 1'b0;
      chk("rel_pc", pc, 16'h0001);
      chk("rel_valid", instr_valid, 1'b0);
      @(negedge clk); chk_show("first", 16'h3011, 16'd1); chk("first_pc", pc, 16'd2);
      @(negedge clk); chk_show("second", 16'h3121, 16'd2);

      // decoder stall on address 5
      wait_shown(16'd5, 20);
      #1 stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_show("stall", 16'h3451, 16'd5);
         chk("stall_pc", pc, 16'd6);
      end
      #1 stall = 1'b0;
      #1 chk_show("release", 16'h3451, 16'd5);
      @(negedge clk); chk_show("after_rel", 16'h3561, 16'd6);
      @(negedge clk); chk_show("after_rel2", 16'h2007, 16'd7);

      // jump predecode at 33 back to 1
      wait_shown(16'd33, 60);
      chk("jump_instr", instr_out, 16'hF001);
      @(negedge clk);
      chk("jump_pc", pc, 16'd1);
      chk("jump_bubble", instr_valid, 1'b0);
      @(negedge clk); chk_show("jump_tgt", 16'h3011, 16'd1);

      // branch while stalled with a full hold
      #1 stall = 1'b1;
      @(negedge clk); chk_show("hold_full", 16'h3011, 16'd1);
      #1 begin branch_taken = 1'b1; branch_target = 16'd34; end
      @(negedge clk);
      chk("br_bubble", instr_valid, 1'b0);
      chk("br_pc", pc, 16'd34);
      #1 begin branch_taken = 1'b0; stall = 1'b0; end
      @(negedge clk); chk_show("br_tgt", 16'h8330, 16'd34);

      // asynchronous reset mid-stall
      #1 stall = 1'b1;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_pc", pc, 16'h0001);
      chk("arst_valid", instr_valid, 1'b0);
      chk("arst_instr", instr_out, 16'h0000);
      chk("arst_instr_pc", instr_pc, 16'h0000);
      stall = 1'b0;
      @(negedge clk); #1 rst = 1'b0;
      chk("arel_valid", instr_valid, 1'b0);
      @(negedge clk); chk_show("afirst", 16'h3011, 16'd1);
      @(negedge clk); chk_show("asecond", 16'h3121, 16'd2);

`ifdef FETCH_IRQ_EN
      wait_shown(16'd10, 20);
      #1 irq = 1'b1;
      #1 chk("irq_valid", instr_valid, 1'b0);
      @(negedge clk);
      chk("irq_epc", epc, 16'd10);
      chk("irq_pc", pc, 16'h0000);
      @(negedge clk); chk_show("irq_v0", 16'h2000, 16'd0);
      @(negedge clk); chk_show("irq_ignored", 16'h3011, 16'd1);
      #1 begin irq_done = 1'b1; irq = 1'b0; end
      @(negedge clk); chk_show("irq_done", 16'h3121, 16'd2);
      #1 begin irq_done = 1'b0; irq = 1'b1; end
      #1 chk("irq2_valid", instr_valid, 1'b0);
      @(negedge clk);
      chk("irq2_epc", epc, 16'd2);
      chk("irq2_pc", pc, 16'h0000);
      #1 irq = 1'b0;
`endif

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
